// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and constants
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int PC_STEP = 4;
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with reset load, aligned redirect load and +4 step
module pc_reg #(
  parameter int W = 32,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_pc,
  output logic [W-1:0] pc
);
  import riscv_pkg::*;
  always_ff @(posedge clk)
    if (rst) pc <= RESET_PC;
    else if (load) pc <= load_pc & ~W'(3);
    else if (inc) pc <= pc + W'(PC_STEP);
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: sequential PC fetch with one outstanding imem request, instruction register
// and redirect handling that drains a stale in-flight response
module instr_fetch #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  import riscv_pkg::*;
  fetch_state_t state;
  logic accept, capture, outstanding;
  assign accept = state == FETCH && imem_req_ready;
  assign capture = state == WAIT && imem_rsp_valid && !redirect_valid;
  // a response arriving this cycle retires the in-flight request, so nothing is left to drain
  assign outstanding = accept || ((state == WAIT || state == DRAIN) && !imem_rsp_valid);
  assign imem_req_valid = state == FETCH && !rst;
  assign instr_valid = state == HOLD;
  pc_reg #(.W(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .inc(capture),
    .load(redirect_valid),
    .load_pc(redirect_pc),
    .pc(imem_req_addr)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= FETCH;
      instr_out <= XLEN'(NOP_INSTR);
      instr_pc <= '0;
    end else begin
      if (capture) begin
        instr_out <= imem_rsp_data;
        instr_pc <= imem_req_addr;
      end
      if (redirect_valid) state <= outstanding ? DRAIN : FETCH;
      else
        case (state)
          FETCH: state <= imem_req_ready ? WAIT : FETCH;
          WAIT:  state <= imem_rsp_valid ? HOLD : WAIT;
          HOLD:  state <= instr_ready ? FETCH : HOLD;
          DRAIN: state <= imem_rsp_valid ? FETCH : DRAIN;
        endcase
    end
endmodule
